// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitors.
package hls_deadlock_pkg;

  // Widest vector the masked reduction helper accepts; callers zero-extend.
  localparam int MASK_W = 64;

  // Widest counter supported; narrower counters slice their all-ones limit from here.
  localparam int MAX_CNT_W = 32;
  localparam logic [MAX_CNT_W-1:0] SAT_ALL_ONES = '1;

  // How child monitor flags combine: any child (single) or all children (parallel).
  typedef enum logic {
    SINGLE   = 1'b0,
    PARALLEL = 1'b1
  } mode_e;

  // True when any bit of vec is set inside mask.
  function automatic logic reduce_masked(input logic [MASK_W-1:0] vec,
                                         input logic [MASK_W-1:0] mask);
    return |(vec & mask);
  endfunction

endpackage

// File: rtl/hls_deadlock_persist_filter.sv
// Persistence filter: qualifies a candidate after THRESHOLD consecutive cycles,
// with optional sticky hold and a synchronous clear.
module hls_deadlock_persist_filter
  import hls_deadlock_pkg::*;
#(
  parameter int THRESHOLD = 1,
  parameter int CNT_W     = 8,
  parameter int STICKY    = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic cand,
  output logic qual,
  output logic block
);

  localparam logic [CNT_W-1:0] PCNT_MAX = SAT_ALL_ONES[CNT_W-1:0];
  localparam logic [CNT_W:0]   THRESH_W = (CNT_W+1)'(THRESHOLD);

  logic [CNT_W-1:0] pcnt_reg, pcnt_next;
  logic [CNT_W:0]   pcnt_inc;
  logic             block_reg, block_next;

  // Candidate run length including the current cycle, compared one bit wider
  // so a saturated counter still meets any legal threshold.
  always_comb begin
    pcnt_inc   = {1'b0, pcnt_reg} + (CNT_W+1)'(1);
    qual       = cand && (pcnt_inc >= THRESH_W);
    pcnt_next  = '0;
    if (cand) begin
      pcnt_next = (pcnt_reg == PCNT_MAX) ? PCNT_MAX : pcnt_inc[CNT_W-1:0];
    end
    block_next = (STICKY != 0) ? (block_reg | qual) : qual;
  end

  // Reset and clear both discard any partial run and drop the flag.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pcnt_reg  <= '0;
      block_reg <= 1'b0;
    end else begin
      pcnt_reg  <= pcnt_next;
      block_reg <= block_next;
    end
  end

  assign block = block_reg;

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Per-node HLS deadlock monitor: combines own AXIS stalls, gated child monitor
// flags and instance idle/block state into a filtered deadlock flag with debug
// snapshot and blocked-cycle count.
module hls_deadlock_monitor_param
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS = 4,
  parameter int NUM_INST = 4,
  parameter int NUM_SUB  = 2,
  parameter logic [NUM_AXIS-1:0]         CUR_AXIS_MASK = 'b0001,
  parameter logic [NUM_SUB*NUM_AXIS-1:0] SUB_AXIS_MASK = 'b1000_0010,
  parameter int PAR_MODE  = 0,
  parameter int THRESHOLD = 1,
  parameter int CNT_W     = 8,
  parameter int STICKY    = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic [NUM_SUB-1:0]  sub_block,
  output logic                block,
  output logic [NUM_AXIS-1:0] cause_axis,
  output logic [NUM_SUB-1:0]  cause_sub,
  output logic [CNT_W-1:0]    block_cycles
);

  localparam mode_e MODE = (PAR_MODE != 0) ? PARALLEL : SINGLE;
  localparam logic [CNT_W-1:0] CYC_MAX = SAT_ALL_ONES[CNT_W-1:0];

  logic [NUM_SUB-1:0] sub_hit;
  logic               cur, subs, inst_term, cand, qual, block_q;

  logic [NUM_AXIS-1:0] cause_axis_reg;
  logic [NUM_SUB-1:0]  cause_sub_reg;
  logic [CNT_W-1:0]    block_cycles_reg;

  // A child's flag only counts while one of its associated channels is stalled.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SUB; gi++) begin : g_sub
      assign sub_hit[gi] = sub_block[gi] &
        reduce_masked(MASK_W'(axis_block_sigs),
                      MASK_W'(SUB_AXIS_MASK[gi*NUM_AXIS +: NUM_AXIS]));
    end
  endgenerate

  // Candidate: own channel stall, child stall, or every instance idle-or-blocked
  // with at least one actually blocked (all-idle is a finished node, not a hang).
  always_comb begin
    cur       = reduce_masked(MASK_W'(axis_block_sigs), MASK_W'(CUR_AXIS_MASK));
    subs      = (MODE == PARALLEL) ? (&sub_hit) : (|sub_hit);
    inst_term = !(&inst_idle_sigs) && (|inst_block_sigs) &&
                (&(inst_block_sigs | inst_idle_sigs));
    cand      = cur | subs | inst_term;
  end

  hls_deadlock_persist_filter #(
    .THRESHOLD (THRESHOLD),
    .CNT_W     (CNT_W),
    .STICKY    (STICKY)
  ) u_filter (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .cand  (cand),
    .qual  (qual),
    .block (block_q)
  );

  // Capture what was stalled on the rising edge of block; count blocked cycles.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cause_axis_reg   <= '0;
      cause_sub_reg    <= '0;
      block_cycles_reg <= '0;
    end else begin
      if (!block_q && qual) begin
        cause_axis_reg <= axis_block_sigs;
        cause_sub_reg  <= sub_block;
      end
      if (block_q && (block_cycles_reg != CYC_MAX)) begin
        block_cycles_reg <= block_cycles_reg + CNT_W'(1);
      end
    end
  end

  assign block        = block_q;
  assign cause_axis   = cause_axis_reg;
  assign cause_sub    = cause_sub_reg;
  assign block_cycles = block_cycles_reg;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Directed bench: five monitor variants share one stimulus and are checked
// against hand-computed expectations.
module tb_hls_deadlock_monitor_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] axis_block_sigs = '0;
  logic [3:0] inst_idle_sigs  = 4'b1111;
  logic [3:0] inst_block_sigs = '0;
  logic [1:0] sub_block       = '0;

  logic       a_block, b_block, c_block, d_block, e_block;
  logic [3:0] a_caxis, b_caxis, c_caxis, d_caxis, e_caxis;
  logic [1:0] a_csub, b_csub, c_csub, d_csub, e_csub;
  logic [7:0] a_cyc, b_cyc, c_cyc, d_cyc;
  logic [3:0] e_cyc;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clock = ~clock;

  // A: defaults (single mode, THRESHOLD=1, non-sticky)
  hls_deadlock_monitor_param u_a (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .sub_block(sub_block),
    .block(a_block), .cause_axis(a_caxis), .cause_sub(a_csub), .block_cycles(a_cyc));

  // B: parallel children
  hls_deadlock_monitor_param #(.PAR_MODE(1)) u_b (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .sub_block(sub_block),
    .block(b_block), .cause_axis(b_caxis), .cause_sub(b_csub), .block_cycles(b_cyc));

  // C: THRESHOLD=4
  hls_deadlock_monitor_param #(.THRESHOLD(4)) u_c (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .sub_block(sub_block),
    .block(c_block), .cause_axis(c_caxis), .cause_sub(c_csub), .block_cycles(c_cyc));

  // D: sticky, THRESHOLD=2
  hls_deadlock_monitor_param #(.THRESHOLD(2), .STICKY(1)) u_d (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .sub_block(sub_block),
    .block(d_block), .cause_axis(d_caxis), .cause_sub(d_csub), .block_cycles(d_cyc));

  // E: 4-bit counters
  hls_deadlock_monitor_param #(.CNT_W(4)) u_e (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .sub_block(sub_block),
    .block(e_block), .cause_axis(e_caxis), .cause_sub(e_csub), .block_cycles(e_cyc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs set after this land on the next edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    axis_block_sigs = '0;
    inst_idle_sigs  = 4'b1111;
    inst_block_sigs = '0;
    sub_block       = '0;
  endtask

  initial begin
    logic [5:0] c_exp;
    c_exp = 6'b111000;  // C block after cand edges 1..6

    // Reset state
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_a_block", 32'(a_block), 32'd0);
    check("rst_a_caxis", 32'(a_caxis), 32'd0);
    check("rst_a_csub",  32'(a_csub),  32'd0);
    check("rst_a_cyc",   32'(a_cyc),   32'd0);

    // Single-cycle own-channel stall with THRESHOLD=1
    axis_block_sigs = 4'b0001;
    step();
    check("t1_a_block_hi", 32'(a_block), 32'd1);
    check("t1_a_caxis",    32'(a_caxis), 32'b0001);
    check("t1_c_block_lo", 32'(c_block), 32'd0);
    axis_block_sigs = 4'b0000;
    step();
    check("t1_a_block_lo", 32'(a_block), 32'd0);
    check("t1_a_cyc",      32'(a_cyc),   32'd1);
    check("t1_a_caxis_hold", 32'(a_caxis), 32'b0001);

    // THRESHOLD=4: short run of 3 never qualifies
    axis_block_sigs = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t2_short_c_block_%0d", i), 32'(c_block), 32'd0);
    end
    axis_block_sigs = 4'b0000;
    step();
    check("t2_gap_c_block", 32'(c_block), 32'd0);
    // Run of 6: block rises after the 4th edge and holds 3 cycles
    axis_block_sigs = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t2_long_c_block_%0d", i), 32'(c_block), 32'(c_exp[i]));
    end
    axis_block_sigs = 4'b0000;
    step();
    check("t2_end_c_block", 32'(c_block), 32'd0);
    check("t2_c_cyc",       32'(c_cyc),   32'd3);
    step();

    // Child gating: single vs parallel
    sub_block = 2'b01;
    axis_block_sigs = 4'b0010;
    step();
    check("t3_a_single_block",   32'(a_block), 32'd1);
    check("t3_b_parallel_block", 32'(b_block), 32'd0);
    sub_block = 2'b11;
    axis_block_sigs = 4'b1010;
    step();
    check("t3_a_both_block", 32'(a_block), 32'd1);
    check("t3_b_both_block", 32'(b_block), 32'd1);
    check("t3_b_csub",       32'(b_csub),  32'b11);
    check("t3_a_csub_hold",  32'(a_csub),  32'b01);
    idle_inputs();
    step();

    // Sticky mode
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4_d_clr_block", 32'(d_block), 32'd0);
    check("t4_d_clr_cyc",   32'(d_cyc),   32'd0);
    axis_block_sigs = 4'b0001;
    step();
    check("t4_d_block_wait", 32'(d_block), 32'd0);
    step();
    check("t4_d_block_set",  32'(d_block), 32'd1);
    axis_block_sigs = 4'b0000;
    step(2);
    check("t4_d_block_hold", 32'(d_block), 32'd1);
    check("t4_d_cyc",        32'(d_cyc),   32'd2);
    check("t4_d_caxis",      32'(d_caxis), 32'b0001);
    axis_block_sigs = 4'b0001;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4_d_clr2_block", 32'(d_block), 32'd0);
    check("t4_d_clr2_cyc",   32'(d_cyc),   32'd0);
    check("t4_d_clr2_caxis", 32'(d_caxis), 32'd0);
    step();
    check("t4_d_redet_wait", 32'(d_block), 32'd0);
    step();
    check("t4_d_redet_set",  32'(d_block), 32'd1);
    idle_inputs();
    step();

    // Instance idle/block term
    inst_idle_sigs  = 4'b0101;
    inst_block_sigs = 4'b1010;
    step();
    check("t5_a_inst_block", 32'(a_block), 32'd1);
    inst_block_sigs = 4'b0010;
    step();
    check("t5_a_inst_noblock", 32'(a_block), 32'd0);
    idle_inputs();
    step();

    // Saturation on 4-bit counters, then reset
    axis_block_sigs = 4'b0001;
    step(20);
    check("t6_e_block", 32'(e_block), 32'd1);
    check("t6_e_cyc",   32'(e_cyc),   32'd15);
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_e_rst_block", 32'(e_block), 32'd0);
    check("t6_e_rst_cyc",   32'(e_cyc),   32'd0);
    check("t6_e_rst_caxis", 32'(e_caxis), 32'd0);
    check("t6_d_rst_block", 32'(d_block), 32'd0);
    check("t6_d_rst_cyc",   32'(d_cyc),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_monitor_param.md
Name: hls_deadlock_monitor_param

Overview:
Parametrised successor of the per-instance HLS deadlock monitor. It combines the instance's own AXIS blocking, child monitor block flags gated by their associated AXIS channels, and instance idle/block state into a deadlock candidate. A persistence filter qualifies the candidate, an optional sticky mode holds the result, and a cause snapshot plus blocked-cycle count are kept for debug readout. One instance sits per HLS dataflow node and feeds its parent monitor's `sub_block` input.

Parameters:
- NUM_AXIS, 4, number of AXIS block signals observed (≥1)
- NUM_INST, 4, number of instance idle/block signals (≥1)
- NUM_SUB, 2, number of child monitors (≥1)
- CUR_AXIS_MASK, 'b0001, NUM_AXIS bits; channels owned directly by this instance
- SUB_AXIS_MASK, 'b1000_0010, NUM_SUB*NUM_AXIS bits; slice i = channels associated with child i
- PAR_MODE, 0, 0 = children single (OR over children), 1 = children parallel (AND over children)
- THRESHOLD, 1, consecutive candidate cycles required before `block` asserts (1..2^CNT_W-1)
- CNT_W, 8, width of persistence and blocked-cycle counters
- STICKY, 0, 1 = `block` holds until `clear` or reset

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear  in  1  synchronous clear of sticky block, cause snapshot and counters
- axis_block_sigs  in  NUM_AXIS  per-channel AXIS blocked
- inst_idle_sigs  in  NUM_INST  per-instance idle
- inst_block_sigs  in  NUM_INST  per-instance blocked
- sub_block  in  NUM_SUB  block outputs of child monitors
- block  out  1  qualified deadlock flag
- cause_axis  out  NUM_AXIS  AXIS snapshot at block assertion
- cause_sub  out  NUM_SUB  child-block snapshot at block assertion
- block_cycles  out  CNT_W  saturating count of cycles with block=1

Behaviour:
- Combinational terms:
  - cur = |(axis_block_sigs & CUR_AXIS_MASK)
  - sub_hit[i] = sub_block[i] & |(axis_block_sigs & SUB_AXIS_MASK[i])
  - subs = PAR_MODE ? &sub_hit : |sub_hit
  - cand = cur | subs | (&inst_idle_sigs==0 & |inst_block_sigs & &(inst_block_sigs | inst_idle_sigs))
  - The last term means: every instance is idle or blocked, and at least one is blocked.
- Persistence counter `pcnt` (CNT_W):
  - If cand=0: pcnt <= 0.
  - If cand=1: pcnt <= pcnt+1, saturating at 2^CNT_W-1.
  - qual = cand & (pcnt+1 ≥ THRESHOLD), compared at CNT_W+1 bits.
- Block register:
  - STICKY=0: block <= qual. With THRESHOLD=1, block follows cand with exactly 1-cycle latency.
  - STICKY=1: block <= block | qual.
- Cause snapshot: on the cycle where block=0 and qual=1, cause_axis <= axis_block_sigs and cause_sub <= sub_block. Otherwise both hold.
- block_cycles increments by 1 each cycle block=1 and saturates at all-ones.
- clear:
  - Next cycle: block=0, pcnt=0, cause_axis=0, cause_sub=0, block_cycles=0.
  - clear has priority over a same-cycle qual. Re-detection requires THRESHOLD fresh cand cycles after the clear cycle.
- reset: all state to 0, same priority as clear. Mid-detection reset discards partial pcnt.
- Outputs are registered only; no combinational path from input to output.

Decomposition:
- Package hls_deadlock_pkg:
  - function reduce_masked(vec, mask)
  - localparam for saturating max
  - typedef for the mode enum (SINGLE=0, PARALLEL=1)
- One sub-module, hls_deadlock_persist_filter: pcnt, qual, sticky, clear. Reused by future monitor variants.
- Mask logic stays in the top.

Test Plan:
- THRESHOLD=1, STICKY=0: axis_block_sigs=0001 for 1 cycle → block=1 the next cycle only; cause_axis=0001; block_cycles=1.
- THRESHOLD=4: cand held 3 cycles then dropped → block stays 0. Then cand held 6 cycles → block rises on the 4th cycle after cand rises and stays 3 cycles; block_cycles=3.
- PAR_MODE=0 vs 1 with sub_block=01, axis=0010 → block=1 in single mode, 0 in parallel mode. With sub_block=11, axis=1010 → block=1 in both modes; cause_sub=11.
- STICKY=1: qualify, then drop cand → block stays 1 and block_cycles keeps counting. Pulse clear together with cand=1 → block=0 next cycle; re-asserts only after THRESHOLD cycles.
- Instance term: inst_idle=0101, inst_block=1010, axis=0 → block=1. Same with inst_block=0010 → block=0.
- Saturation (CNT_W=4): block held 20 cycles → block_cycles=15. Then assert reset for 1 cycle → all outputs 0 the next cycle.
